// File: rtl/voice_allocator_if.sv
// rtl/voice_allocator_if.sv - note event handshake and oscillator pool outputs of the voice allocator
interface voice_allocator_if #(
    parameter int NUM_VOICES = 7,
    parameter int NOTE_W     = 7
);
    localparam int CNT_W = $clog2(NUM_VOICES + 1);

    logic                         note_valid;
    logic                         note_on;
    logic [NOTE_W-1:0]            note_num;
    logic                         all_off;
    logic                         note_ready;
    logic [NUM_VOICES-1:0]        voice_en;
    logic [NUM_VOICES*NOTE_W-1:0] voice_note;
    logic [NUM_VOICES-1:0]        voice_load;
    logic [CNT_W-1:0]             active_count;

    modport master (
        output note_valid, note_on, note_num, all_off,
        input  note_ready, voice_en, voice_note, voice_load, active_count
    );

    modport slave (
        input  note_valid, note_on, note_num, all_off,
        output note_ready, voice_en, voice_note, voice_load, active_count
    );
endinterface

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - polyphonic voice allocator: scans voices for match/free/oldest and drives the oscillator pool
module voice_allocator #(
    parameter int NUM_VOICES = 7,
    parameter int NOTE_W     = 7,
    parameter int AGE_W      = 3
) (
    input  logic               clk,
    input  logic               resetn,
    voice_allocator_if.slave   bus
);
    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam int CNT_W = $clog2(NUM_VOICES + 1);

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    state_t                state;
    logic [IDX_W-1:0]      scan_idx;
    logic                  ev_on;
    logic [NOTE_W-1:0]     ev_num;
    logic                  match_found, free_found, old_found;
    logic [IDX_W-1:0]      match_idx, free_idx, old_idx;
    logic [AGE_W-1:0]      old_age;
    logic [NUM_VOICES-1:0] en;
    logic [NUM_VOICES-1:0] load;
    logic [NOTE_W-1:0]     note_q [NUM_VOICES];
    logic [AGE_W-1:0]      age    [NUM_VOICES];
    logic [CNT_W-1:0]      count;
    logic                  ready;

    logic [IDX_W-1:0]      tgt;
    logic [NUM_VOICES-1:0] en_commit;
    logic [CNT_W-1:0]      cnt_commit;

    // Enables as they will look after COMMIT, so the count can be registered alongside them
    always_comb begin
        tgt        = match_found ? match_idx : (free_found ? free_idx : old_idx);
        en_commit  = en;
        if (ev_on)
            en_commit[tgt] = 1'b1;
        else if (match_found)
            en_commit[match_idx] = 1'b0;
        cnt_commit = '0;
        for (int k = 0; k < NUM_VOICES; k++)
            cnt_commit = cnt_commit + CNT_W'(en_commit[k]);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            scan_idx    <= '0;
            ev_on       <= 1'b0;
            ev_num      <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            old_found   <= 1'b0;
            match_idx   <= '0;
            free_idx    <= '0;
            old_idx     <= '0;
            old_age     <= '0;
            en          <= '0;
            load        <= '0;
            count       <= '0;
            ready       <= 1'b1;
            for (int k = 0; k < NUM_VOICES; k++) begin
                note_q[k] <= '0;
                age[k]    <= '0;
            end
        end else begin
            load <= '0;
            case (state)
                IDLE: begin
                    if (bus.all_off) begin
                        en    <= '0;
                        count <= '0;
                        for (int k = 0; k < NUM_VOICES; k++)
                            age[k] <= '0;
                    end else if (bus.note_valid) begin
                        ev_on       <= bus.note_on;
                        ev_num      <= bus.note_num;
                        scan_idx    <= '0;
                        match_found <= 1'b0;
                        free_found  <= 1'b0;
                        old_found   <= 1'b0;
                        old_age     <= '0;
                        ready       <= 1'b0;
                        state       <= SCAN;
                    end
                end
                SCAN: begin
                    if (en[scan_idx]) begin
                        if (!match_found && note_q[scan_idx] == ev_num) begin
                            match_found <= 1'b1;
                            match_idx   <= scan_idx;
                        end
                        // Strict compare keeps the lowest index on equal ages
                        if (!old_found || age[scan_idx] > old_age) begin
                            old_found <= 1'b1;
                            old_idx   <= scan_idx;
                            old_age   <= age[scan_idx];
                        end
                    end else if (!free_found) begin
                        free_found <= 1'b1;
                        free_idx   <= scan_idx;
                    end
                    if (scan_idx == IDX_W'(NUM_VOICES - 1))
                        state <= COMMIT;
                    else
                        scan_idx <= scan_idx + 1'b1;
                end
                COMMIT: begin
                    en    <= en_commit;
                    count <= cnt_commit;
                    if (ev_on) begin
                        note_q[tgt] <= ev_num;
                        load        <= NUM_VOICES'(1) << tgt;
                        for (int k = 0; k < NUM_VOICES; k++) begin
                            if (k == int'(tgt))
                                age[k] <= '0;
                            else if (en[k] && age[k] != '1)
                                age[k] <= age[k] + 1'b1;
                        end
                    end else if (match_found) begin
                        age[match_idx] <= '0;
                    end
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.voice_note = '0;
        for (int k = 0; k < NUM_VOICES; k++)
            bus.voice_note[k*NOTE_W +: NOTE_W] = note_q[k];
    end

    assign bus.note_ready   = ready;
    assign bus.voice_en     = en;
    assign bus.voice_load   = load;
    assign bus.active_count = count;
endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphonic voice allocator between the MIDI receive path and the oscillator bank of the synth core. Each accepted note event is sequenced through a per-voice scan that picks a matching, free or oldest voice. The block then drives the per-oscillator enable and note-number registers. It owns the oscillator pool exclusively; no other block writes voice enables or voice notes.

## Interface
- NUM_VOICES, 7, number of oscillator voices managed (2..15)
- NOTE_W, 7, MIDI note number width
- AGE_W, 3, per-voice age counter width; must satisfy 2^AGE_W ≥ NUM_VOICES

- clk_i  in  1  system clock; single clock domain
- nrst_i  in  1  reset, synchronous, active-low
- noteValid_i  in  1  note event valid
- noteOn_i  in  1  1 = note-on, 0 = note-off; qualified by noteValid_i
- noteNum_i  in  NOTE_W  note number; qualified by noteValid_i
- allOff_i  in  1  panic request; releases every voice
- noteReady_o  out  1  block can accept an event or panic request
- voiceEn_o  out  NUM_VOICES  per-voice gate to the oscillators
- voiceNote_o  out  NUM_VOICES*NOTE_W  voice k note at bits [k*NOTE_W +: NOTE_W]
- voiceLoad_o  out  NUM_VOICES  one-cycle strobe; voice k (re)started with new note
- activeCount_o  out  $clog2(NUM_VOICES+1)  number of set bits in voiceEn_o

## Operation
- FSM states: IDLE, SCAN, COMMIT.
- IDLE: noteReady_o=1.
  - allOff_i=1 takes priority over noteValid_i. It clears all voiceEn_o bits and all ages in one cycle, with no voiceLoad_o pulse. State stays IDLE.
  - noteValid_i=1 with allOff_i=0 latches noteOn_i and noteNum_i, then goes to SCAN with index 0.
- SCAN: one voice per cycle, index 0..NUM_VOICES-1. The scan records three candidates:
  - match: first voice with voiceEn=1 and note equal to the latched number.
  - free: first voice with voiceEn=0.
  - oldest: voice with the highest age among enabled voices; ties go to the lowest index.
  - After the last index, go to COMMIT.
- COMMIT, note-on:
  - Target selection priority is match (retrigger), then free, then oldest (steal).
  - Target effects: voiceEn=1, note loaded, age=0, voiceLoad_o bit pulsed.
  - All other enabled voices increment age, saturating at 2^AGE_W-1.
- COMMIT, note-off:
  - With a match: clear that voice's voiceEn and set its age to 0. voiceNote keeps its old value. No load pulse.
  - Without a match: no state change.
- After COMMIT, return to IDLE.
- Inputs presented while noteReady_o=0 are ignored; no queueing. Upstream must hold noteValid_i until it sees valid&ready.
- activeCount_o is registered and updated together with voiceEn_o.

## Timing
- Reset (nrst_i=0 at a clock edge):
  - State goes to IDLE from any state, including mid-SCAN; the latched event is discarded.
  - Outputs: noteReady_o=1, voiceEn_o=0, voiceNote_o=0, voiceLoad_o=0, activeCount_o=0.
  - All ages are cleared to 0.
- Event handshake at edge T (valid&ready):
  - noteReady_o=0 from T+1.
  - SCAN occupies T+1..T+NUM_VOICES.
  - COMMIT register update occurs at edge T+NUM_VOICES+1.
- After that edge, voiceEn_o, voiceNote_o, activeCount_o and the voiceLoad_o pulse are all visible in the same cycle. noteReady_o returns to 1 in that cycle.
- Throughput: one event per NUM_VOICES+2 cycles (9 for the default).
- allOff latency: outputs cleared in the cycle after the accepting edge; noteReady_o stays 1.
- voiceLoad_o is exactly one cycle wide and one-hot or zero.

## Test plan
- Reset: hold nrst_i=0 for 2 cycles mid-SCAN, release. Required: voiceEn_o=0, activeCount_o=0, noteReady_o=1 immediately, and no voiceLoad_o pulse.
- Basic allocation: note-on 60, 64, 67 back-to-back. Required:
  - Voices 0, 1, 2 enabled with notes 60, 64, 67; activeCount_o=3.
  - voiceLoad_o=0b001, 0b010, 0b100.
  - Each event updates outputs 8 cycles after its handshake edge.
- Stealing: note-on 60..66 fill all 7 voices, then note-on 70. Required: voice 0 (oldest, note 60) gets note 70, voiceLoad_o=0b0000001, activeCount_o=7.
- Retrigger and release:
  - Note-on 64 while voice 1 holds 64: voiceLoad_o=0b0000010, no new voice, voice 1 age=0.
  - Then note-off 64: voiceEn_o[1]=0, voiceNote of voice 1 still 64.
  - Then note-off 99 (unheld): no output change.
- Handshake: hold noteValid_i=1 with a second note during SCAN. Required: it is accepted only on the cycle noteReady_o returns to 1, and is processed exactly once.
- Panic: 5 voices active, assert allOff_i and noteValid_i together in IDLE. Required: voiceEn_o=0 and activeCount_o=0 next cycle, and the note event is not consumed.
